// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the burst master.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [1:0] HSIZE_BYTE = 2'b00;
    localparam logic [1:0] HSIZE_HALF = 2'b01;
    localparam logic [1:0] HSIZE_WORD = 2'b10;

    localparam logic [3:0] HBURST_INCR = 4'b0001;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_NSEQ, ST_SEQ} state_t;

    // Size 11 is not supported by the bridge; fold it onto word.
    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == 2'b11) ? HSIZE_WORD : s;
    endfunction
endpackage

// File: rtl/ahb_addr_gen.sv
// Next-beat address for an INCR burst plus a flag when that address lands on a BOUND edge.
module ahb_addr_gen import ahb_pkg::*; #(
    parameter int BOUND = 1024
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    output logic [31:0] next_addr,
    output logic        crosses_bound
);
    localparam int BW = $clog2(BOUND);

    logic [31:0] incr;

    always_comb begin
        incr = 32'd4;
        case (size)
            HSIZE_BYTE: incr = 32'd1;
            HSIZE_HALF: incr = 32'd2;
            default:    incr = 32'd4;
        endcase
    end

    assign next_addr     = addr + incr;
    assign crosses_bound = (next_addr[BW-1:0] == '0);
endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite INCR burst master: command/write/read handshakes in, pipelined NSEQ/SEQ/BUSY out.
module ahb_burst_master import ahb_pkg::*; #(
    parameter int LEN_W = 8,
    parameter int BOUND = 1024
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [1:0]       cmd_size,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [31:0]      wdata,
    output logic             rdata_valid,
    output logic [31:0]      rdata,
    output logic             done,
    output logic             done_err,
    output logic             hsel,
    output logic [1:0]       htrans,
    output logic [1:0]       hsize,
    output logic [3:0]       hburst,
    output logic             hwrite,
    output logic [31:0]      haddr,
    output logic [31:0]      hwdata,
    input  logic             hready,
    input  logic [31:0]      hrdata,
    input  logic [2:0]       hresp
);
    state_t           state;
    logic [LEN_W-1:0] cnt, len_q;
    logic             write_q, bnd_q, err;
    logic             dp_valid, dp_write, dp_last;
    logic [31:0]      next_addr;
    logic             crosses;
    logic             accepted, err_now, last_beat, cmd_fire, unused_resp;

    ahb_addr_gen #(.BOUND(BOUND)) u_addr_gen (
        .addr          (haddr),
        .size          (hsize),
        .next_addr     (next_addr),
        .crosses_bound (crosses)
    );

    assign hburst      = HBURST_INCR;
    assign accepted    = hready & htrans[1];
    assign err_now     = dp_valid & hready & (hresp[0] != HRESP_OKAY);
    assign last_beat   = (cnt == len_q);
    assign cmd_ready   = (state == ST_IDLE) & hready & ~hreset;
    assign cmd_fire    = cmd_valid & cmd_ready;
    assign wdata_ready = accepted & hwrite & ~hreset;
    assign unused_resp = ^hresp[2:1];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state       <= ST_IDLE;
            htrans      <= HTRANS_IDLE;
            hsel        <= 1'b0;
            haddr       <= '0;
            hsize       <= HSIZE_BYTE;
            hwrite      <= 1'b0;
            hwdata      <= '0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            done        <= 1'b0;
            done_err    <= 1'b0;
            cnt         <= '0;
            len_q       <= '0;
            write_q     <= 1'b0;
            bnd_q       <= 1'b0;
            err         <= 1'b0;
            dp_valid    <= 1'b0;
            dp_write    <= 1'b0;
            dp_last     <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            done_err    <= 1'b0;
            if (hready) begin
                if (dp_valid) begin
                    if (!dp_write) begin
                        rdata_valid <= 1'b1;
                        rdata       <= hrdata;
                    end
                    if (err_now || dp_last) begin
                        done     <= 1'b1;
                        done_err <= err | err_now;
                    end
                    if (err_now) err <= 1'b1;
                end
                // A beat accepted alongside an ERROR completion is dropped, so no second done.
                dp_valid <= accepted & ~err_now;
                dp_write <= hwrite;
                dp_last  <= accepted & last_beat;
                if (wdata_ready) hwdata <= wdata;

                case (state)
                    ST_IDLE: begin
                        htrans <= HTRANS_IDLE;
                        hsel   <= 1'b0;
                        if (cmd_fire) begin
                            state   <= ST_NSEQ;
                            haddr   <= cmd_addr;
                            hsize   <= norm_size(cmd_size);
                            hwrite  <= cmd_write;
                            write_q <= cmd_write;
                            len_q   <= cmd_len;
                            cnt     <= '0;
                            err     <= 1'b0;
                            hsel    <= 1'b1;
                            htrans  <= (cmd_write && !wdata_valid) ? HTRANS_IDLE : HTRANS_NSEQ;
                        end
                    end
                    default: begin
                        if (err_now || (accepted && last_beat)) begin
                            state  <= ST_IDLE;
                            htrans <= HTRANS_IDLE;
                            hsel   <= 1'b0;
                        end else if (accepted) begin
                            state  <= ST_SEQ;
                            cnt    <= cnt + 1'b1;
                            haddr  <= next_addr;
                            bnd_q  <= crosses;
                            if (write_q && !wdata_valid) htrans <= HTRANS_BUSY;
                            else htrans <= crosses ? HTRANS_NSEQ : HTRANS_SEQ;
                        end else if (!write_q || wdata_valid) begin
                            // Leaving a write wait (IDLE in NSEQ, BUSY in SEQ) at the held address.
                            if (state == ST_NSEQ) htrans <= HTRANS_NSEQ;
                            else htrans <= bnd_q ? HTRANS_NSEQ : HTRANS_SEQ;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/ahb_burst_master.md
Name: ahb_burst_master

Overview:
- AHB-Lite master that sits directly upstream of the AHB-to-SRAM bridge and drives its slave port.
- Converts simple command, write-data and read-data handshakes into AHB NONSEQ/SEQ/BUSY/IDLE transfers with a pipelined address and data phase.
- Honours slave wait states, including the one-cycle stall the bridge inserts for a write data phase followed by a read address phase.
- Used by test/DMA logic to fill and read back the SRAM banks in bursts.

Parameters:
- LEN_W, 8, width of cmd_len; a burst is cmd_len+1 beats (1..256).
- BOUND, 1024, byte boundary an INCR burst must not cross; power of two.

Ports:
- hclk  in  1  clock.
- hreset  in  1  reset; one clock hclk; reset is synchronous and active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  32  start byte address, aligned to cmd_size.
- cmd_size  in  2  00 byte, 01 half, 10 word (11 treated as 10).
- cmd_len  in  LEN_W  beats minus one.
- wdata_valid  in  1  write data available.
- wdata_ready  out  1  write beat consumed.
- wdata  in  32  write data, lane-placed by the bridge.
- rdata_valid  out  1  one-cycle pulse per completed read beat.
- rdata  out  32  read data, valid with rdata_valid.
- done  out  1  one-cycle pulse when the last data phase of a command completes.
- done_err  out  1  valid with done; 1 if any beat returned ERROR.
- hsel  out  1  slave select.
- htrans  out  2  AHB trans type.
- hsize  out  2  transfer size.
- hburst  out  4  fixed 4'b0001 (INCR).
- hwrite  out  1  direction.
- haddr  out  32  address.
- hwdata  out  32  write data for the current data phase.
- hready  in  1  slave ready (bridge hready_o).
- hrdata  in  32  slave read data.
- hresp  in  3  bit0: 1=ERROR, 0=OKAY; bits [2:1] ignored.

Behaviour:
- Reset (synchronous, hreset=1 at a hclk edge): FSM enters IDLE.
  - htrans=00, hsel=0, haddr=0, hsize=0, hwrite=0, hwdata=0.
  - cmd_ready=0 during the reset cycle.
  - rdata_valid=0, done=0, done_err=0.
  - All counters and data-phase flags are cleared.
  - A reset mid-burst abandons the burst without a done pulse.
- Address signals change only on edges where hready=1; they hold while hready=0.
- FSM states:
  - IDLE: cmd_ready=1, htrans=IDLE. Accepting a command latches addr/size/len/write and goes to NSEQ.
  - NSEQ:
    - Drives htrans=10, hsel=1.
    - For a write, it is entered or held only with wdata_valid=1; otherwise it drives htrans=00 and waits.
    - Accepted (hready=1) beat: if it was the last beat, go to IDLE; else go to SEQ.
  - SEQ:
    - Drives htrans=11 with haddr += (1<<size).
    - On a write with wdata_valid=0, drives BUSY (01) and holds haddr/beat count.
    - If the next address is a multiple of BOUND, the beat is issued as NONSEQ instead of SEQ.
    - The last accepted beat goes to IDLE.
- wdata_ready=1 exactly on edges where a write NONSEQ/SEQ address phase is accepted.
  - wdata is registered into hwdata at that edge.
  - hwdata holds until the next accepted write beat.
- Data-phase flags (dp_valid, dp_write, dp_last) load at every hready=1 edge from the current address phase.
- Read completion: dp_valid & ~dp_write & hready=1 gives rdata_valid=1 and rdata=hrdata (registered, one cycle after the data-phase end).
- Command overlap: IDLE is re-entered after the last address is accepted, so the next command's NONSEQ may overlap the previous last data phase.
  - done fires for the old command when that data phase completes.
  - done and a new cmd acceptance may coincide.
- Error: hresp[0]=1 on a completing data phase sets a sticky err flag.
  - Remaining beats are cancelled: htrans=IDLE, FSM goes to IDLE.
  - done pulses with done_err=1 on that completion.
  - err clears on the next cmd acceptance.
- Latency:
  - cmd accept to first NONSEQ: 1 cycle.
  - Read beat with zero wait: data phase ends 1 cycle after its address phase; rdata_valid follows 1 cycle later.
- The beat counter is LEN_W bits wide. cmd_len=255 gives 256 beats without overflow, and the last-beat compare uses the counter equal to cmd_len.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE/BUSY/NSEQ/SEQ.
  - HSIZE_BYTE/HALF/WORD.
  - HBURST_INCR.
  - HRESP_OKAY/ERROR.
  - FSM state typedef.
- One natural sub-module: ahb_addr_gen. It takes the current addr and size and returns the next addr plus a crosses_bound flag.

Test Plan:
- Write, addr=0x0000_0010, size=10, len=3, wdata 0xA0..0xA3 always valid, hready=1 → htrans NSEQ,SEQ,SEQ,SEQ; haddr 0x10,0x14,0x18,0x1C; hwdata A0..A3 one cycle later; done=1, done_err=0.
- Write len=1 to 0x0, then read len=0 from 0x4 back-to-back, bridge stalls hready=0 for 1 cycle → read NONSEQ held 2 cycles with haddr=0x4 stable; rdata_valid once with the bridge data.
- Write, size=00, len=3, wdata_valid dropped for 2 cycles after beat 1 → two BUSY cycles at haddr=0x1; bytes 0x0..0x3 written; wdata_ready pulses exactly 4 times.
- Read, addr=0x3F8, size=10, len=3 → htrans NSEQ,SEQ,NSEQ,SEQ at 0x3F8,0x3FC,0x400,0x404; 4 rdata_valid pulses.
- Read len=7, hresp[0]=1 on beat 2 → htrans IDLE next cycle; done=1, done_err=1; next command's done_err=0.
- hreset=1 asserted mid-write burst beat 2 → next cycle htrans=00, hsel=0, cmd_ready=1 after release, no done pulse.
